// File: rtl/byte_ram_ctrl.sv
// byte_ram_ctrl: byte-enable data memory with sub-word loads, sequenced clear and a debug display port
// Ports: clk, rst (sync, active-high); req_* valid/ready request channel (we, sel, signed, addr, wdata);
//        rsp_valid/rsp_rdata/rsp_err read response; busy during clear; disp_addr/disp_data debug read.
module byte_ram_ctrl #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [DATA_W/8-1:0]   req_sel,
    input  logic                  req_signed,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  busy,
    input  logic [ADDR_W-1:0]     disp_addr,
    output logic [DATA_W-1:0]     disp_data
);
    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t              state, state_nx;
    logic [ADDR_W-1:0]   cnt;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic                acc;
    logic [DATA_W:0]     rd_ext;
    logic                p1_v, p1_e, p2_v, p2_e;
    logic [DATA_W-1:0]   p1_d, p2_d;

    // Tries every aligned power-of-two lane run; anything that matches none is an error with zero data.
    function automatic logic [DATA_W:0] extract(input logic [DATA_W-1:0] w, input logic [NB-1:0] sel,
                                                input logic sgn);
        logic [DATA_W-1:0] keep, sh;
        logic [NB-1:0]     m;
        extract = {1'b1, {DATA_W{1'b0}}};
        for (int l = 0; (1 << l) <= NB; l++) begin
            for (int o = 0; o < NB; o += (1 << l)) begin
                m    = NB'(((1 << (1 << l)) - 1) << o);
                keep = {DATA_W{1'b1}} >> (DATA_W - 8 * (1 << l));
                sh   = (w >> (8 * o)) & keep;
                // ~keep is empty for a full word, so req_signed has no effect there
                if (sel == m)
                    extract = {1'b0, sh | ((sgn && sh[8 * (1 << l) - 1]) ? ~keep : {DATA_W{1'b0}})};
            end
        end
    endfunction

    assign busy      = state == CLEAR;
    assign req_ready = state == RUN;
    assign acc       = req_valid & req_ready & ~rst;
    assign rd_ext    = extract(mem[req_addr], req_sel, req_signed);

    always_comb begin
        state_nx = state;
        if (state == CLEAR && &cnt) state_nx = RUN;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (busy) cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && busy) mem[cnt] <= '0;
        else if (acc && req_we)
            for (int k = 0; k < NB; k++)
                if (req_sel[k]) mem[req_addr][8*k +: 8] <= req_wdata[8*k +: 8];
    end

    // Two-stage response pipe; data/err only advance with a valid entry so outputs hold between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            {p1_v, p1_e, p1_d} <= '0;
            {p2_v, p2_e, p2_d} <= '0;
            disp_data          <= '0;
        end else begin
            p1_v <= acc & ~req_we;
            if (acc && !req_we) {p1_e, p1_d} <= rd_ext;
            p2_v <= p1_v;
            if (p1_v) {p2_e, p2_d} <= {p1_e, p1_d};
            disp_data <= busy ? '0 : mem[disp_addr];
        end
    end

    assign rsp_valid = (READ_LAT == 2) ? p2_v : p1_v;
    assign rsp_err   = (READ_LAT == 2) ? p2_e : p1_e;
    assign rsp_rdata = (READ_LAT == 2) ? p2_d : p1_d;
endmodule

// File: tb/tb_byte_ram_ctrl.sv
// tb_byte_ram_ctrl: randomized and directed check of byte_ram_ctrl at READ_LAT 1 and 2 against a reference model
module tb_byte_ram_ctrl;
    localparam int AW = 4, DW = 32, DEPTH = 16;

    logic clk = 0, rst = 1, req_valid = 0, req_we = 0, req_signed = 0;
    logic [3:0]    req_sel = '0;
    logic [AW-1:0] req_addr = '0, disp_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [1:0]    rv, re, bsy, rdy;
    logic [DW-1:0] rd [2];
    logic [DW-1:0] dd [2];

    always #5 clk = ~clk;

    byte_ram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[0]), .req_we(req_we),
        .req_sel(req_sel), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv[0]), .rsp_rdata(rd[0]), .rsp_err(re[0]), .busy(bsy[0]),
        .disp_addr(disp_addr), .disp_data(dd[0]));

    byte_ram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[1]), .req_we(req_we),
        .req_sel(req_sel), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv[1]), .rsp_rdata(rd[1]), .rsp_err(re[1]), .busy(bsy[1]),
        .disp_addr(disp_addr), .disp_data(dd[1]));

    typedef struct {int due; logic e; logic [31:0] d;} ent_t;

    int          checks = 0, errors = 0, edge_n = 0, clr = 0;
    bit          m_busy = 1;
    logic [31:0] mem_m [DEPTH];
    ent_t        q [2][$];
    logic [31:0] last_d [2] = '{0, 0};
    logic        last_e [2] = '{0, 0};
    logic [31:0] got_d [2] = '{0, 0};
    logic        got_e [2] = '{0, 0};
    int          pulses [2] = '{0, 0};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [32:0] ref_read(input logic [31:0] w, input logic [3:0] sel, input logic sgn);
        int lo, n;
        logic [63:0] mask, v;
        n  = $countones(sel);
        lo = 0;
        for (int k = 3; k >= 0; k--) if (sel[k]) lo = k;
        if (!(n == 1 || n == 2 || n == 4) || (lo % n) != 0 || sel != 4'(((1 << n) - 1) << lo))
            return {1'b1, 32'd0};
        mask = (64'd1 << (8 * n)) - 1;
        v    = ({32'd0, w} >> (8 * lo)) & mask;
        if (sgn && v[8 * n - 1]) v = v | ~mask;
        return {1'b0, v[31:0]};
    endfunction

    task automatic step();
        bit          acc;
        logic [31:0] disp_exp;
        logic [32:0] r;
        acc      = req_valid && !m_busy && !rst;
        disp_exp = (rst || m_busy) ? 32'd0 : mem_m[disp_addr];
        @(posedge clk);
        edge_n++;
        if (rst) begin
            m_busy = 1;
            clr    = DEPTH;
            for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
            for (int d = 0; d < 2; d++) begin
                q[d].delete();
                last_d[d] = '0;
                last_e[d] = 0;
            end
        end else if (m_busy) begin
            clr--;
            if (clr <= 0) m_busy = 0;
        end
        if (acc && req_we) begin
            for (int k = 0; k < 4; k++) if (req_sel[k]) mem_m[req_addr][8*k +: 8] = req_wdata[8*k +: 8];
        end else if (acc) begin
            r = ref_read(mem_m[req_addr], req_sel, req_signed);
            for (int d = 0; d < 2; d++) q[d].push_back('{edge_n + d, r[32], r[31:0]});
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            bit exp_v;
            exp_v = q[d].size() > 0 && q[d][0].due == edge_n;
            if (exp_v) begin
                last_d[d] = q[d][0].d;
                last_e[d] = q[d][0].e;
                void'(q[d].pop_front());
            end
            if (rv[d]) begin
                got_d[d] = rd[d];
                got_e[d] = re[d];
                pulses[d]++;
            end
            check($sformatf("busy%0d", d + 1), bsy[d], m_busy);
            check($sformatf("ready%0d", d + 1), rdy[d], !m_busy);
            check($sformatf("disp%0d", d + 1), dd[d], disp_exp);
            check($sformatf("rsp_valid%0d", d + 1), rv[d], exp_v);
            check($sformatf("rsp_rdata%0d", d + 1), rd[d], last_d[d]);
            check($sformatf("rsp_err%0d", d + 1), re[d], last_e[d]);
        end
    endtask

    task automatic idle();
        req_valid = 0;
        step();
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] w, input logic [3:0] s);
        req_valid = 1; req_we = 1; req_addr = a; req_wdata = w; req_sel = s; req_signed = 0;
        step();
        req_valid = 0;
    endtask

    task automatic rdq(input logic [AW-1:0] a, input logic [3:0] s, input logic sg);
        req_valid = 1; req_we = 0; req_addr = a; req_sel = s; req_signed = sg;
        step();
        req_valid = 0;
    endtask

    task automatic rd_chk(input string tag, input logic [AW-1:0] a, input logic [3:0] s, input logic sg,
                          input logic [31:0] exp_d, input logic exp_e);
        rdq(a, s, sg);
        idle();
        idle();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s_data%0d", tag, d + 1), got_d[d], exp_d);
            check($sformatf("%s_err%0d", tag, d + 1), got_e[d], exp_e);
        end
    endtask

    task automatic clear_len(input string tag);
        int n;
        n = 0;
        while (bsy[0] && n < 40) begin
            idle();
            n++;
        end
        check(tag, n, DEPTH);
    endtask

    initial begin
        int p0;
        rst = 1;
        step();
        step();
        rst = 0;
        clear_len("init_busy_len");

        wr(3, 32'hDEADBEEF, 4'hF);
        rd_chk("prefill", 3, 4'hF, 0, 32'hDEADBEEF, 0);
        rst = 1;
        step();
        rst = 0;
        clear_len("rst_busy_len");
        rd_chk("cleared", 3, 4'hF, 0, 32'h0, 0);

        wr(5, 32'h0000AB00, 4'b0010);
        rd_chk("b_word", 5, 4'hF, 0, 32'h0000AB00, 0);
        rd_chk("b_u", 5, 4'b0010, 0, 32'h000000AB, 0);
        rd_chk("b_s", 5, 4'b0010, 1, 32'hFFFFFFAB, 0);

        wr(7, 32'h80017FFF, 4'hF);
        rd_chk("h_hi_s", 7, 4'b1100, 1, 32'hFFFF8001, 0);
        rd_chk("h_lo_s", 7, 4'b0011, 1, 32'h00007FFF, 0);
        rd_chk("h_hi_u", 7, 4'b1100, 0, 32'h00008001, 0);

        rd_chk("ill_0101", 7, 4'b0101, 0, 32'h0, 1);
        rd_chk("ill_0110", 7, 4'b0110, 1, 32'h0, 1);
        rd_chk("ill_0000", 7, 4'b0000, 0, 32'h0, 1);
        rd_chk("ill_0111", 7, 4'b0111, 0, 32'h0, 1);
        rd_chk("ill_keep", 7, 4'hF, 0, 32'h80017FFF, 0);
        wr(7, 32'hFFFFFFFF, 4'b0000);
        rd_chk("sel0_wr", 7, 4'hF, 0, 32'h80017FFF, 0);

        disp_addr = 9;
        wr(9, 32'h12345678, 4'hF);
        rdq(9, 4'hF, 0);
        check("disp9", dd[0], 32'h12345678);
        idle();
        idle();
        check("raw1", got_d[0], 32'h12345678);
        check("raw2", got_d[1], 32'h12345678);

        p0 = pulses[1];
        for (int i = 0; i < 8; i++) rdq(AW'(i), 4'hF, 0);
        idle();
        idle();
        check("stream8", pulses[1] - p0, 8);

        p0 = pulses[1];
        rdq(9, 4'hF, 0);
        rst = 1;
        step();
        rst = 0;
        clear_len("midrd_busy_len");
        check("midrd_no_rsp", pulses[1] - p0, 0);

        rst = 1;
        step();
        rst = 0;
        for (int i = 0; i < 5; i++) idle();
        rst = 1;
        step();
        rst = 0;
        clear_len("rerst_busy_len");

        for (int i = 0; i < 600; i++) begin
            req_valid  = $urandom_range(0, 3) != 0;
            req_we     = $urandom_range(0, 2) == 0;
            req_sel    = 4'($urandom);
            req_signed = 1'($urandom);
            req_addr   = AW'($urandom);
            req_wdata  = $urandom;
            disp_addr  = AW'($urandom);
            rst        = $urandom_range(0, 199) == 0;
            step();
        end
        rst = 0;
        req_valid = 0;
        for (int i = 0; i < 20; i++) idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
